rv32i_top: RTL and testbench



---
 rtl/rv32i_pkg.sv | 43 ++++
 rtl/alu.sv | 36 +++
 rtl/control_unit.sv | 139 +++++++++++++
 rtl/register_file.sv | 32 +++
 rtl/rv32i_top.sv | 136 +++++++++++++
 tb/tb_rv32i_top.sv | 193 +++++++++++++++++++
 6 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared decode types, ALU function codes and RV32I opcodes.
// Rev 1.0
`default_nettype none

package rv32i_pkg;

  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, SLIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ERROR
  } cuOPType;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// alu -- 32-bit RV32I integer ALU; shift amount comes from operand B[4:0].
// Rev 1.0
`default_nettype none

module alu
  import rv32i_pkg::*;
(
  input  logic [3:0]  alu_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (alu_op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'b0, a_i < b_i};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// control_unit -- decodes one RV32I instruction into operation, ALU function, operand select and immediate.
// Rev 1.0
`default_nettype none

module control_unit
  import rv32i_pkg::*;
(
  input  logic [31:0] instr_i,
  output cuOPType     cu_op_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_src_o,
  output logic [31:0] imm_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    cu_op_o = ERROR;
    case (opcode)
      OPC_LUI:   cu_op_o = LUI;
      OPC_AUIPC: cu_op_o = AUIPC;
      OPC_JAL:   cu_op_o = JAL;
      OPC_JALR:  cu_op_o = (funct3 == 3'b000) ? JALR : ERROR;
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  cu_op_o = BEQ;
          3'b001:  cu_op_o = BNE;
          3'b100:  cu_op_o = BLT;
          3'b101:  cu_op_o = BGE;
          3'b110:  cu_op_o = BLTU;
          3'b111:  cu_op_o = BGEU;
          default: cu_op_o = ERROR;
        endcase
      end
      OPC_LOAD: begin
        case (funct3)
          3'b000:  cu_op_o = LB;
          3'b001:  cu_op_o = LH;
          3'b010:  cu_op_o = LW;
          3'b100:  cu_op_o = LBU;
          3'b101:  cu_op_o = LHU;
          default: cu_op_o = ERROR;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'b000:  cu_op_o = SB;
          3'b001:  cu_op_o = SH;
          3'b010:  cu_op_o = SW;
          default: cu_op_o = ERROR;
        endcase
      end
      OPC_OPIMM: begin
        case (funct3)
          3'b000: cu_op_o = ADDI;
          3'b010: cu_op_o = SLTI;
          3'b011: cu_op_o = SLTIU;
          3'b100: cu_op_o = XORI;
          3'b110: cu_op_o = ORI;
          3'b111: cu_op_o = ANDI;
          3'b001: cu_op_o = (funct7 == F7_BASE) ? SLLI : ERROR;
          3'b101: cu_op_o = (funct7 == F7_BASE) ? SRLI :
                            (funct7 == F7_ALT)  ? SRAI : ERROR;
          default: cu_op_o = ERROR;
        endcase
      end
      OPC_OP: begin
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: cu_op_o = ADD;
          {F7_ALT,  3'b000}: cu_op_o = SUB;
          {F7_BASE, 3'b001}: cu_op_o = SLL;
          {F7_BASE, 3'b010}: cu_op_o = SLT;
          {F7_BASE, 3'b011}: cu_op_o = SLTU;
          {F7_BASE, 3'b100}: cu_op_o = XOR;
          {F7_BASE, 3'b101}: cu_op_o = SRL;
          {F7_ALT,  3'b101}: cu_op_o = SRA;
          {F7_BASE, 3'b110}: cu_op_o = OR;
          {F7_BASE, 3'b111}: cu_op_o = AND;
          default:           cu_op_o = ERROR;
        endcase
      end
      default: cu_op_o = ERROR;
    endcase
  end

  // Branches compare through the ALU; every other non-ALU op uses ADD.
  always_comb begin
    alu_op_o  = ALU_ADD;
    alu_src_o = 1'b0;
    case (cu_op_o)
      BEQ, BNE:     alu_op_o = ALU_SUB;
      BLT, BGE:     alu_op_o = ALU_SLT;
      BLTU, BGEU:   alu_op_o = ALU_SLTU;
      JALR, LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI: alu_src_o = 1'b1;
      SLTI:  begin alu_op_o = ALU_SLT;  alu_src_o = 1'b1; end
      SLTIU: begin alu_op_o = ALU_SLTU; alu_src_o = 1'b1; end
      XORI:  begin alu_op_o = ALU_XOR;  alu_src_o = 1'b1; end
      ORI:   begin alu_op_o = ALU_OR;   alu_src_o = 1'b1; end
      ANDI:  begin alu_op_o = ALU_AND;  alu_src_o = 1'b1; end
      SLLI:  begin alu_op_o = ALU_SLL;  alu_src_o = 1'b1; end
      SRLI:  begin alu_op_o = ALU_SRL;  alu_src_o = 1'b1; end
      SRAI:  begin alu_op_o = ALU_SRA;  alu_src_o = 1'b1; end
      SUB:   alu_op_o = ALU_SUB;
      SLL:   alu_op_o = ALU_SLL;
      SLT:   alu_op_o = ALU_SLT;
      SLTU:  alu_op_o = ALU_SLTU;
      XOR:   alu_op_o = ALU_XOR;
      SRL:   alu_op_o = ALU_SRL;
      SRA:   alu_op_o = ALU_SRA;
      OR:    alu_op_o = ALU_OR;
      AND:   alu_op_o = ALU_AND;
      default: ;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (cu_op_o)
      LUI, AUIPC: imm_o = {instr_i[31:12], 12'b0};
      JAL: imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      BEQ, BNE, BLT, BGE, BLTU, BGEU:
        imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      SB, SH, SW: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      SLLI, SRLI, SRAI: imm_o = {27'b0, instr_i[24:20]};
      JALR, LB, LH, LW, LBU, LHU, ADDI, SLTI, SLTIU, XORI, ORI, ANDI:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      default: imm_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// register_file -- 32x32 register file, x0 hardwired to zero, no write-to-read bypass.
// Rev 1.0
`default_nettype none

module register_file (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/rv32i_top.sv
// rv32i_top -- single-cycle RV32I execution core; fetch and data memory are external.
// Rev 1.0
`default_nettype none

module rv32i_top
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] instruction,
  input  logic [31:0] memload,
  output logic [31:0] pc,
  output logic [5:0]  cuOP,
  output logic [4:0]  regsel1,
  output logic [4:0]  regsel2,
  output logic [4:0]  w_reg,
  output logic [19:0] imm,
  output logic [31:0] immOut,
  output logic [31:0] regData1,
  output logic [31:0] regData2,
  output logic        aluSrc,
  output logic [31:0] aluIn,
  output logic [3:0]  aluOP,
  output logic [31:0] aluOut,
  output logic        zero,
  output logic        negative,
  output logic [31:0] writeData
);

  cuOPType     cu_op;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4, pc_imm;
  logic        reg_we, br_taken;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign regsel1 = instruction[19:15];
  assign regsel2 = instruction[24:20];
  assign w_reg   = instruction[11:7];
  assign imm     = instruction[31:12];
  assign cuOP    = cu_op;
  assign pc      = pc_q;

  control_unit u_control_unit (
    .instr_i   (instruction),
    .cu_op_o   (cu_op),
    .alu_op_o  (aluOP),
    .alu_src_o (aluSrc),
    .imm_o     (immOut)
  );

  register_file u_register_file (
    .clk_i    (clk),
    .rst_i    (nrst),
    .we_i     (reg_we),
    .waddr_i  (w_reg),
    .wdata_i  (writeData),
    .raddr1_i (regsel1),
    .raddr2_i (regsel2),
    .rdata1_o (regData1),
    .rdata2_o (regData2)
  );

  assign aluIn = aluSrc ? immOut : regData2;

  alu u_alu (
    .alu_op_i (aluOP),
    .a_i      (regData1),
    .b_i      (aluIn),
    .result_o (aluOut)
  );

  assign zero     = (aluOut == 32'd0);
  assign negative = aluOut[31];
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_imm   = pc_q + immOut;

  // SLT/SLTU leave 1 in aluOut when "less than", so BLT/BLTU are taken on !zero.
  always_comb begin
    br_taken = 1'b0;
    case (cu_op)
      BEQ, BGE, BGEU: br_taken = zero;
      BNE, BLT, BLTU: br_taken = !zero;
      default:        br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_d = pc_plus4;
    if (cu_op == JAL || br_taken) pc_d = pc_imm;
    else if (cu_op == JALR)       pc_d = aluOut & ~32'd1;
  end

  always_comb begin
    ld_byte = memload[7:0];
    case (aluOut[1:0])
      2'd1:    ld_byte = memload[15:8];
      2'd2:    ld_byte = memload[23:16];
      2'd3:    ld_byte = memload[31:24];
      default: ld_byte = memload[7:0];
    endcase
  end

  assign ld_half = aluOut[1] ? memload[31:16] : memload[15:0];

  always_comb begin
    writeData = aluOut;
    case (cu_op)
      LUI:       writeData = immOut;
      AUIPC:     writeData = pc_imm;
      JAL, JALR: writeData = pc_plus4;
      LB:        writeData = {{24{ld_byte[7]}}, ld_byte};
      LH:        writeData = {{16{ld_half[15]}}, ld_half};
      LW:        writeData = memload;
      LBU:       writeData = {24'b0, ld_byte};
      LHU:       writeData = {16'b0, ld_half};
      default:   writeData = aluOut;
    endcase
  end

  always_comb begin
    reg_we = 1'b1;
    case (cu_op)
      BEQ, BNE, BLT, BGE, BLTU, BGEU, SB, SH, SW, ERROR: reg_we = 1'b0;
      default: reg_we = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) pc_q <= '0;
    else      pc_q <= pc_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_top.sv
// tb_rv32i_top -- directed self-checking bench for the single-cycle RV32I core.
// Rev 1.0
`default_nettype none

module tb_rv32i_top;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] instruction, memload;
  logic [31:0] pc, immOut, regData1, regData2, aluIn, aluOut, writeData;
  logic [5:0]  cuOP;
  logic [4:0]  regsel1, regsel2, w_reg;
  logic [19:0] imm;
  logic [3:0]  aluOP;
  logic        aluSrc, zero, negative;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  rv32i_top dut (
    .clk(clk), .nrst(nrst), .instruction(instruction), .memload(memload),
    .pc(pc), .cuOP(cuOP), .regsel1(regsel1), .regsel2(regsel2), .w_reg(w_reg),
    .imm(imm), .immOut(immOut), .regData1(regData1), .regData2(regData2),
    .aluSrc(aluSrc), .aluIn(aluIn), .aluOP(aluOP), .aluOut(aluOut),
    .zero(zero), .negative(negative), .writeData(writeData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present an instruction a little after the edge and let the combinational path settle.
  task automatic present(input logic [31:0] ins);
    instruction = ins;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst        = 1'b1;
    instruction = NOP;
    memload     = 32'd0;
    tick();
    tick();
    chk("reset_pc", pc, 32'd0);
    nrst = 1'b0;

    // ADDI x1,x0,1000
    present(32'h3e800093);
    chk("addi1_wd", writeData, 32'h000003E8);
    chk("addi1_cuop", {26'b0, cuOP}, 32'd18);
    chk("addi1_alusrc", {31'b0, aluSrc}, 32'd1);
    tick();
    chk("addi1_pc", pc, 32'd4);
    present(32'h00008013);
    chk("x1_read", regData1, 32'd1000);
    tick();
    // ADDI x2,x0,-2000
    present(32'h83000113);
    chk("addi2_imm", immOut, 32'hFFFFF830);
    chk("addi2_wd", writeData, 32'hFFFFF830);
    chk("addi2_neg", {31'b0, negative}, 32'd1);
    tick();
    present(32'h3E906193);            // ORI x3,x0,1001
    chk("ori_wd", writeData, 32'h000003E9);
    tick();
    present(32'h45707213);            // ANDI x4,x0,1111
    chk("andi0_wd", writeData, 32'd0);
    chk("andi0_zero", {31'b0, zero}, 32'd1);
    tick();
    present(32'h3f31f213);            // ANDI x4,x3,1011
    chk("andi_rs1", regData1, 32'h000003E9);
    chk("andi_wd", writeData, 32'h000003E1);
    tick();
    present(32'h7D000113);            // ADDI x2,x0,2000
    chk("addi2000_wd", writeData, 32'h000007D0);
    tick();
    present(32'hC1800193);            // ADDI x3,x0,-1000
    chk("addim1000_wd", writeData, 32'hFFFFFC18);
    tick();
    chk("pre_branch_pc", pc, 32'h20);

    present(32'h00108463);            // BEQ x1,x1,+8
    chk("beq_cuop", {26'b0, cuOP}, 32'd4);
    tick();
    chk("beq_taken_pc", pc, 32'h28);
    present(32'h00308463);            // BEQ x1,x3,+8
    tick();
    chk("beq_nt_pc", pc, 32'h2C);
    present(32'h0011C463);            // BLT x3,x1,+8
    chk("blt_rd1", regData1, 32'hFFFFFC18);
    chk("blt_rd2", regData2, 32'd1000);
    tick();
    chk("blt_taken_pc", pc, 32'h34);
    present(32'h0011E463);            // BLTU x3,x1,+8
    tick();
    chk("bltu_nt_pc", pc, 32'h38);
    present(32'h0030F463);            // BGEU x1,x3,+8
    tick();
    chk("bgeu_nt_pc", pc, 32'h3C);
    present(32'h00115463);            // BGE x2,x1,+8
    tick();
    chk("bge_taken_pc", pc, 32'h44);

    present(32'h00202223);            // SW x2,4(x0)
    chk("sw_addr", aluOut, 32'd4);
    chk("sw_alusrc", {31'b0, aluSrc}, 32'd1);
    tick();
    present(32'h00020013);            // read x4: store must not have written it
    chk("x4_after_sw", regData1, 32'h000003E1);
    tick();
    present(32'h00040013);            // read x8: branches carried rd=8
    chk("x8_after_br", regData1, 32'd0);
    tick();
    present(32'h12345337);            // LUI x6,0x12345
    chk("lui_imm", {12'b0, imm}, 32'h00012345);
    chk("lui_wd", writeData, 32'h12345000);
    tick();
    present(32'hFFFFFFFF);            // undecodable
    chk("error_cuop", {26'b0, cuOP}, 32'd38);
    tick();
    present(32'h000F8013);            // read x31
    chk("x31_after_err", regData1, 32'd0);
    tick();
    present(32'h00108093);            // ADDI x1,x1,1: reads old value
    chk("rdw_old", regData1, 32'd1000);
    chk("rdw_wd", writeData, 32'd1001);
    tick();
    chk("rdw_new", regData1, 32'd1001);

    // Reset with a write pending
    nrst = 1'b1;
    #1;
    tick();
    chk("midrst_pc", pc, 32'd0);
    for (int i = 0; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      present({7'b0, r, r, 3'b000, 5'd0, 7'h13});
      chk($sformatf("rst_rs1_x%0d", i), regData1, 32'd0);
      chk($sformatf("rst_rs2_x%0d", i), regData2, 32'd0);
    end
    instruction = NOP;
    nrst        = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("nop_pc", pc, 32'h20);

    present(32'h010000EF);            // JAL x1,+16
    chk("jal_imm", immOut, 32'h10);
    chk("jal_wd", writeData, 32'h24);
    tick();
    chk("jal_pc", pc, 32'h30);
    present(32'h00508067);            // JALR x0,x1,5
    chk("jalr_rd1", regData1, 32'h24);
    tick();
    chk("jalr_pc", pc, 32'h28);

    memload = 32'h000080FF;
    present(32'h00100283);            // LB x5,1(x0)
    chk("lb_addr", aluOut, 32'd1);
    chk("lb_wd", writeData, 32'hFFFFFF80);
    tick();
    present(32'h00028013);
    chk("x5_read", regData1, 32'hFFFFFF80);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
